echo_delay_fb: RTL and testbench
================================

Name: echo_delay_fb

Overview:
Parametrised successor to the single-tap delay used in the effects chain. It stores each incoming sample in a circular block-RAM buffer and reads back a sample from a programmable distance behind it. The delayed sample is fed back into the buffer through a programmable feedback gain, giving a decaying echo. The output is the dry sample plus the delayed sample scaled by a wet-mix gain. It sits between the sample-rate strobe source and the audio output path, one sample per start pulse.

Parameters:
WIDTH, 12, signed sample width in bits.
ADDR_W, 13, buffer address width; DEPTH = 2^ADDR_W samples.
DELAY_W, 5, width of delay_amount.
DELAY_SHIFT, 8, delay in samples = delay_amount << DELAY_SHIFT. Required: (2^DELAY_W - 1) << DELAY_SHIFT is at most DEPTH-1.

Ports:
clock  in  1  system clock; all state is on its rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle strobe that marks a new sample.
incoming_sample  in  WIDTH  signed dry sample.
delay_amount  in  DELAY_W  delay setting; 0 means bypass.
feedback  in  3  feedback gain = feedback/8.
mix  in  3  wet gain = mix/8.
modified_sample  out  WIDTH  signed processed sample.
done  out  1  one-cycle pulse when modified_sample is updated.
busy  out  1  high during buffer clear or sample processing.
current_pointer  out  ADDR_W  write address.
delayed_pointer  out  ADDR_W  read address.

Behaviour:
- Reset (reset low, asynchronous):
  - modified_sample, done, current_pointer and delayed_pointer go to 0.
  - busy goes to 1.
  - FSM enters CLEAR with the clear counter at 0.
- FSM states and transitions:
  - CLEAR: writes 0 to address = clear counter on each cycle. After address DEPTH-1 is written, goes to IDLE and busy falls. This takes DEPTH cycles after reset release.
  - IDLE: busy=0. start high at edge k does the following:
    - latches incoming_sample, feedback, mix and delay_amount;
    - sets delayed_pointer = (current_pointer - (delay_amount<<DELAY_SHIFT)) mod DEPTH;
    - goes to READ and sets busy=1.
  - READ (edge k+1): issues the buffer read at delayed_pointer.
  - CALC (edge k+2): registers the read data d (synchronous-read RAM, 1-cycle latency).
  - WRITE (edge k+3):
    - writes w to buffer[current_pointer];
    - updates modified_sample = y;
    - done=1 for exactly this cycle;
    - current_pointer increments mod DEPTH, wrapping DEPTH-1 to 0;
    - returns to IDLE with busy=0.
- Latency: done is high the cycle after edge k+3. The minimum start-to-start spacing is 4 cycles.
- start is ignored while busy, including during CLEAR. An ignored start has no effect and is not queued.
- Arithmetic: x is the latched incoming_sample, d is the read data.
  - w = sat(x + ((d*feedback) >>> 3)).
  - y = sat(x + ((d*mix) >>> 3)).
  - Products are computed at WIDTH+3 bits. >>> is an arithmetic shift (floor).
  - Sums are computed at WIDTH+4 bits.
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Bypass: when delay_amount=0, y = x regardless of mix. w = x is still written, and the pointer still advances.
- Parameter changes take effect only at the next start. Inputs are sampled only at the start edge.
- Reset asserted mid-operation aborts the current operation: no done pulse, and the CLEAR sweep restarts from address 0.
- Buffer contents are undefined only until CLEAR completes. Reads never return uncleared data, because start is ignored until then.
- delayed_pointer holds its last value in IDLE. Both pointers are registered outputs.

Test Plan:
1. Reset release, bench with ADDR_W=4 -> busy stays 1 for exactly 16 cycles, then 0. done stays 0. Pointers are 0. A start pulsed during CLEAR produces no done.
2. ADDR_W=4, DELAY_SHIFT=0, delay_amount=4, mix=7, feedback=0; impulse 800 then zeros -> outputs 800,0,0,0,700,0,0,0,... (700 = floor(800*7/8)). done comes 3 edges after each start.
3. Same setup with feedback=4, mix=7, impulse 1000 -> echoes at 4-sample spacing: 875, 437, 218, ... Buffer write values are 1000, 500, 250, ...
4. Saturation, WIDTH=12: sample 2047 held, delay 4, mix=7, feedback=7 -> output clamps at 2047. A negative run of -2048 clamps at -2048 with no wrap.
5. Bypass: delay_amount=0, input ramp 1,2,3 -> outputs 1,2,3. current_pointer advances 0 to 1 to 2 to 3. delayed_pointer equals current_pointer at each start.
6. Wrap and abuse, ADDR_W=4:
   - 20 samples -> current_pointer wraps 15 to 0;
   - delayed_pointer = (current_pointer - 4) mod 16;
   - start asserted at start+1 and start+2 is ignored, giving exactly one done;
   - reset pulled low at edge k+2 -> no done, and CLEAR restarts.

Source files
------------

// File: rtl/echo_delay_fb.sv
// Feedback echo: circular RAM delay line with programmable tap distance,
// feedback gain and wet mix, one sample per start strobe.
module echo_delay_fb #(
  parameter int WIDTH       = 12,
  parameter int ADDR_W      = 13,
  parameter int DELAY_W     = 5,
  parameter int DELAY_SHIFT = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  incoming_sample,
  input  logic [DELAY_W-1:0]       delay_amount,
  input  logic [2:0]               feedback,
  input  logic [2:0]               mix,
  output logic signed [WIDTH-1:0]  modified_sample,
  output logic                     done,
  output logic                     busy,
  output logic [ADDR_W-1:0]        current_pointer,
  output logic [ADDR_W-1:0]        delayed_pointer
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]              state;
  logic [ADDR_W-1:0]       clr_cnt;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] d_q;
  logic [WIDTH-1:0]        rd_q;
  logic [2:0]              fb_q;
  logic [2:0]              mix_q;
  logic                    byp_q;
  logic [ADDR_W-1:0]       dly_off;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [WIDTH-1:0]        wd;
  logic signed [WIDTH-1:0] w_val;
  logic signed [WIDTH-1:0] y_val;

  // x + floor(d*g/8), clamped to the sample range
  function automatic logic signed [WIDTH-1:0] mac(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] d,
    input logic [2:0]              g
  );
    logic signed [WIDTH+2:0] p;
    logic signed [WIDTH+3:0] s;
    logic signed [WIDTH-1:0] r;
    p = $signed({{3{d[WIDTH-1]}}, d}) *
        $signed({{WIDTH{1'b0}}, g});
    s = $signed({{4{x[WIDTH-1]}}, x}) +
        $signed({{4{p[WIDTH+2]}}, p[WIDTH+2:3]});
    if (s[WIDTH+3] && !(&s[WIDTH+3:WIDTH-1]))
      r = {1'b1, {(WIDTH-1){1'b0}}};
    else if (!s[WIDTH+3] && (|s[WIDTH+2:WIDTH-1]))
      r = {1'b0, {(WIDTH-1){1'b1}}};
    else
      r = s[WIDTH-1:0];
    return r;
  endfunction

  assign dly_off = ADDR_W'(delay_amount) << DELAY_SHIFT;
  assign w_val   = byp_q ? x_q : mac(x_q, d_q, fb_q);
  assign y_val   = byp_q ? x_q : mac(x_q, d_q, mix_q);

  always_comb begin
    we = 1'b0;
    wa = current_pointer;
    wd = w_val;
    if (state == S_CLEAR) begin
      we = 1'b1;
      wa = clr_cnt;
      wd = '0;
    end else if (state == S_WRITE) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (we)
      mem[wa] <= wd;
    rd_q <= mem[delayed_pointer];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_CLEAR;
      clr_cnt         <= '0;
      busy            <= 1'b1;
      done            <= 1'b0;
      modified_sample <= '0;
      current_pointer <= '0;
      delayed_pointer <= '0;
      x_q             <= '0;
      d_q             <= '0;
      fb_q            <= '0;
      mix_q           <= '0;
      byp_q           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (start) begin
            x_q             <= incoming_sample;
            fb_q            <= feedback;
            mix_q           <= mix;
            byp_q           <= (delay_amount == '0);
            delayed_pointer <= current_pointer - dly_off;
            state           <= S_READ;
            busy            <= 1'b1;
          end
        end
        S_READ: state <= S_CALC;
        S_CALC: begin
          d_q   <= $signed(rd_q);
          state <= S_WRITE;
        end
        S_WRITE: begin
          modified_sample <= y_val;
          done            <= 1'b1;
          current_pointer <= current_pointer + 1'b1;
          state           <= S_IDLE;
          busy            <= 1'b0;
        end
        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_fb.sv
// Directed bench for echo_delay_fb with a 16-entry buffer
// and hand-computed expected samples.
module tb_echo_delay_fb;

  logic               clock;
  logic               reset;
  logic               start;
  logic signed [11:0] incoming_sample;
  logic [3:0]         delay_amount;
  logic [2:0]         feedback;
  logic [2:0]         mix;
  logic signed [11:0] modified_sample;
  logic               done;
  logic               busy;
  logic [3:0]         current_pointer;
  logic [3:0]         delayed_pointer;

  int checks = 0;
  int errors = 0;
  int ptr = 0;

  echo_delay_fb #(
    .WIDTH(12),
    .ADDR_W(4),
    .DELAY_W(4),
    .DELAY_SHIFT(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .incoming_sample(incoming_sample),
    .delay_amount(delay_amount),
    .feedback(feedback),
    .mix(mix),
    .modified_sample(modified_sample),
    .done(done),
    .busy(busy),
    .current_pointer(current_pointer),
    .delayed_pointer(delayed_pointer)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clear(input bit poke);
    int n;
    int dn;
    n  = 0;
    dn = 0;
    while (busy && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (done) dn++;
      start = poke && (n == 5);
    end
    start = 1'b0;
    chk("clear_len", n, 16);
    chk("clear_done", dn, 0);
    chk("clear_cp", current_pointer, 0);
    chk("clear_dp", delayed_pointer, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ptr = 0;
    wait_clear(1'b0);
  endtask

  task automatic smp(input int x, input int dl, input int fb,
                     input int mx, input int ey, input string tag);
    int n;
    @(negedge clock);
    start           = 1'b1;
    incoming_sample = x[11:0];
    delay_amount    = dl[3:0];
    feedback        = fb[2:0];
    mix             = mx[2:0];
    @(posedge clock);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_dp"}, delayed_pointer, (ptr - dl) & 15);
    n = 0;
    while (!done && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_y"}, modified_sample, ey);
    ptr = (ptr + 1) & 15;
    chk({tag, "_cp"}, current_pointer, ptr);
  endtask

  int exp2 [9]  = '{800, 0, 0, 0, 700, 0, 0, 0, 0};
  int exp3 [13] = '{1000, 0, 0, 0, 875, 0, 0, 0,
                    437, 0, 0, 0, 218};

  initial begin
    int dn;
    reset           = 1'b0;
    start           = 1'b0;
    incoming_sample = '0;
    delay_amount    = '0;
    feedback        = '0;
    mix             = '0;

    // reset state and clear sweep with an ignored start
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_cp", current_pointer, 0);
    chk("rst_dp", delayed_pointer, 0);
    chk("rst_y", modified_sample, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_clear(1'b1);

    // bypass ramp
    smp(1, 0, 3, 5, 1, "byp1");
    smp(2, 0, 3, 5, 2, "byp2");
    smp(3, 0, 3, 5, 3, "byp3");

    // single echo, no feedback
    do_reset();
    for (int i = 0; i < 9; i++)
      smp(i == 0 ? 800 : 0, 4, 0, 7, exp2[i], "echo");

    // decaying echo with feedback
    do_reset();
    for (int i = 0; i < 13; i++)
      smp(i == 0 ? 1000 : 0, 4, 4, 7, exp3[i], "fb");

    // saturation both ways
    do_reset();
    for (int i = 0; i < 8; i++)
      smp(2047, 4, 7, 7, 2047, "satp");
    for (int i = 0; i < 4; i++)
      smp(-2048, 4, 7, 7, -257, "satn_a");
    for (int i = 0; i < 6; i++)
      smp(-2048, 4, 7, 7, -2048, "satn_b");

    // pointer wrap over 20 samples
    do_reset();
    for (int i = 0; i < 20; i++)
      smp(i, 4, 0, 0, i, "wrap");

    // start held across busy cycles gives one done
    @(negedge clock);
    start           = 1'b1;
    incoming_sample = 12'sd123;
    delay_amount    = 4'd0;
    dn              = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (i == 2) start = 1'b0;
      if (done) dn++;
    end
    chk("hold_dones", dn, 1);
    chk("hold_y", modified_sample, 123);
    ptr = (ptr + 1) & 15;
    chk("hold_cp", current_pointer, ptr);

    // reset during processing aborts and restarts clear
    @(negedge clock);
    start           = 1'b1;
    incoming_sample = 12'sd500;
    delay_amount    = 4'd4;
    mix             = 3'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    dn    = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      if (done) dn++;
    end
    chk("abort_done", dn, 0);
    chk("abort_busy", busy, 1);
    chk("abort_cp", current_pointer, 0);
    chk("abort_y", modified_sample, 0);
    @(negedge clock);
    reset = 1'b1;
    ptr   = 0;
    wait_clear(1'b0);
    smp(5, 4, 7, 7, 5, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
